mem_arbiter: RTL

- Single-port memory arbiter between the pipeline's instruction-fetch port and data port, in front of one shared RAM.
- Grants one access at a time. Data has priority over instruction fetch, with an anti-starvation cap on consecutive data grants.
- Holds the address, type and write data of the granted request, waits for RAM completion, then returns a one-cycle hit pulse with registered load data to the pipeline.
- Blocks new grants on halt so the pipeline can drain cleanly.

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 108 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Pipeline-side and RAM-side signals of the shared-memory arbiter.
// slave is the arbiter's view; master is the pipeline/RAM environment's view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              halt;
    logic              ihit;
    logic              dhit;
    logic [DATA_W-1:0] iload;
    logic [DATA_W-1:0] dload;
    logic              ram_ren;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ready;
    logic              idle;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ram_rdata, ram_ready,
        output ihit, dhit, iload, dload, ram_ren, ram_wen, ram_addr, ram_wdata, idle
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ram_rdata, ram_ready,
        input  ihit, dhit, iload, dload, ram_ren, ram_wen, ram_addr, ram_wdata, idle
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data ports.
// Data wins unless an instruction fetch has waited through MAX_D_STREAK data grants.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic           CLK,
    input  logic           nRST,
    mem_arbiter_if.slave   bus
);
    localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] SMAX = SW'(MAX_D_STREAK);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] IACC = 2'd1;
    localparam logic [1:0] DACC = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]        state;
    logic [SW-1:0]     streak;
    logic              ihit, dhit, ram_ren, ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, iload, dload;
    logic              grant_d, grant_i, d_req, cap_hit;

    // nRST gates the grant so idle reads high while reset is held.
    always_comb begin
        d_req   = bus.dREN | bus.dWEN;
        cap_hit = bus.iREN && (streak == SMAX);
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == IDLE && nRST && !bus.halt) begin
            if (d_req && !cap_hit)
                grant_d = 1'b1;
            else if (bus.iREN)
                grant_i = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            streak    <= '0;
            ihit      <= 1'b0;
            dhit      <= 1'b0;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            iload     <= '0;
            dload     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state     <= DACC;
                        ram_addr  <= bus.daddr;
                        ram_wdata <= bus.dstore;
                        ram_wen   <= bus.dWEN;
                        ram_ren   <= !bus.dWEN;
                        if (!bus.iREN)
                            streak <= '0;
                        else if (streak != SMAX)
                            streak <= streak + SW'(1);
                    end else if (grant_i) begin
                        state    <= IACC;
                        ram_addr <= bus.iaddr;
                        ram_ren  <= 1'b1;
                        ram_wen  <= 1'b0;
                        streak   <= '0;
                    end
                end
                IACC, DACC: begin
                    if (bus.ram_ready) begin
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                        state   <= RESP;
                        if (state == IACC) begin
                            iload <= bus.ram_rdata;
                            ihit  <= 1'b1;
                        end else begin
                            if (!ram_wen)
                                dload <= bus.ram_rdata;
                            dhit <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    ihit  <= 1'b0;
                    dhit  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ihit      = ihit;
    assign bus.dhit      = dhit;
    assign bus.iload     = iload;
    assign bus.dload     = dload;
    assign bus.ram_ren   = ram_ren;
    assign bus.ram_wen   = ram_wen;
    assign bus.ram_addr  = ram_addr;
    assign bus.ram_wdata = ram_wdata;
    assign bus.idle      = (state == IDLE) && !grant_d && !grant_i;
endmodule
